// File: rtl/imem_port_arbiter.sv
// Shares the single-port instruction memory between CPU fetch and a background loader.
// The loader holds the port in bursts of at most MAX_BURST words and then yields one fetch slot.
module imem_port_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_ce_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_data_o,
  output logic              if_valid_o,
  output logic              if_stall_o,
  input  logic              ld_req_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [DATA_W-1:0] ld_data_i,
  input  logic              ld_last_i,
  output logic              ld_gnt_o,
  output logic              ld_done_o,
  output logic [ADDR_W-1:0] ld_count_o,
  output logic              mem_ce_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int BW = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  typedef enum logic [1:0] {FETCH, LOAD, YIELD, DONE} state_t;

  state_t            state, state_nxt;
  logic              in_load, accept, rd_vld;
  logic [BW-1:0]     burst_cnt;
  logic [ADDR_W-1:0] ld_cnt;

  assign in_load = (state == LOAD);
  assign accept  = in_load & ld_req_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FETCH;
    else      state <= state_nxt;
  end

  // last word wins over the burst limit so a session never ends with a stray yield
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH: if (ld_req_i) state_nxt = LOAD;
      LOAD: begin
        if (accept) begin
          if (ld_last_i)                    state_nxt = DONE;
          else if (burst_cnt == BURST_LAST) state_nxt = YIELD;
        end
      end
      YIELD:   state_nxt = LOAD;
      DONE:    state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  always_comb begin
    mem_ce_o    = if_ce_i;
    mem_we_o    = 1'b0;
    mem_addr_o  = if_addr_i;
    mem_wdata_o = '0;
    ld_gnt_o    = 1'b0;
    if_stall_o  = 1'b0;
    if (in_load) begin
      mem_ce_o    = ld_req_i;
      mem_we_o    = ld_req_i;
      mem_addr_o  = ld_addr_i;
      mem_wdata_o = ld_data_i;
      ld_gnt_o    = ld_req_i;
      if_stall_o  = if_ce_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_cnt    <= '0;
      burst_cnt <= '0;
    end else if (state == FETCH && ld_req_i) begin
      ld_cnt    <= '0;
      burst_cnt <= '0;
    end else if (accept) begin
      ld_cnt    <= ld_cnt + ADDR_W'(1);
      burst_cnt <= burst_cnt + BW'(1);
    end else if (state == YIELD) begin
      burst_cnt <= '0;
    end
  end

  // read return tracks the cycle it was issued, whoever owns the port next
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_vld <= 1'b0;
    else      rd_vld <= ~in_load & if_ce_i;
  end

  assign if_valid_o = rd_vld;
  assign if_data_o  = rd_vld ? mem_rdata_i : '0;
  assign ld_done_o  = (state == DONE);
  assign ld_count_o = ld_cnt;

endmodule
